// File: rtl/lmem_sched_ctrl.sv
// rtl/lmem_sched_ctrl.sv - Lmem sequencer for the layered QC-LDPC decoder
// Orders codeword load, per-layer read/write passes, early stop and hard-decision unload.
module lmem_sched_ctrl #(
  parameter int ADDRDEPTH    = 20,
  parameter int ADDRESSWIDTH = 5,
  parameter int LAYERS       = 2,
  parameter int LOAD_DEPTH   = 17,
  parameter int UNLOAD_DEPTH = 16,
  parameter int WR_DELAY     = 14,
  parameter int MAXITRS      = 10,
  parameter int ITRWIDTH     = 4,
  parameter int UNLOAD_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    load_valid,
  input  logic                    syndrome_ok,
  output logic                    loaden,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] rd_address,
  output logic                    rd_layer,
  output logic                    wr_en,
  output logic                    wr_layer,
  output logic                    firstprocessing_indicate,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  output logic                    hd_valid,
  output logic [ITRWIDTH-1:0]     itr_count,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_A  = (ADDRDEPTH > LOAD_DEPTH) ? ADDRDEPTH : LOAD_DEPTH;
  localparam int MAX_B  = (WR_DELAY > UNLOAD_DEPTH + UNLOAD_LAT) ? WR_DELAY : UNLOAD_DEPTH + UNLOAD_LAT;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNTW_R = $clog2(MAX_C);
  localparam int CNTW   = (CNTW_R > ADDRESSWIDTH) ? CNTW_R : ADDRESSWIDTH;

  localparam logic [CNTW-1:0]     LOAD_LAST   = CNTW'(LOAD_DEPTH - 1);
  localparam logic [CNTW-1:0]     RD_LAST     = CNTW'(ADDRDEPTH - 1);
  localparam logic [CNTW-1:0]     DRAIN_LAST  = CNTW'(WR_DELAY - 1);
  localparam logic [CNTW-1:0]     UNL_DEPTH_C = CNTW'(UNLOAD_DEPTH);
  localparam logic [CNTW-1:0]     UNL_LAST    = CNTW'(UNLOAD_DEPTH + UNLOAD_LAT - 1);
  localparam logic [ITRWIDTH-1:0] ITR_LAST    = ITRWIDTH'(MAXITRS - 1);
  localparam logic                LAYER_LAST  = 1'(LAYERS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RD, DRAIN, UNLOAD, FIN} state_t;

  state_t              state, state_nx;
  logic [CNTW-1:0]     cnt, cnt_nx;
  logic                layer, layer_nx;
  logic [ITRWIDTH-1:0] itr, itr_nx;
  logic [WR_DELAY-1:0] wd_en, wd_layer;
  logic [UNLOAD_LAT-1:0] hd_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      layer    <= 1'b0;
      itr      <= '0;
      wd_en    <= '0;
      wd_layer <= '0;
      hd_pipe  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      layer    <= layer_nx;
      itr      <= itr_nx;
      wd_en    <= {wd_en[WR_DELAY-2:0], rd_en};
      wd_layer <= {wd_layer[WR_DELAY-2:0], rd_layer};
      hd_pipe  <= {hd_pipe[UNLOAD_LAT-2:0], unload_en};
    end
  end

  // One shared counter: beat index in LOAD, address in RD, drain/unload phase elsewhere.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    layer_nx = layer;
    itr_nx   = itr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
          layer_nx = 1'b0;
          itr_nx   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (cnt == LOAD_LAST) begin
            state_nx = RD;
            cnt_nx   = '0;
            layer_nx = 1'b0;
          end else begin
            cnt_nx = cnt + CNTW'(1);
          end
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNTW'(1);
        end
      end
      DRAIN: begin
        // Exit on the cycle carrying the layer's last write so the next read abuts it.
        if (cnt == DRAIN_LAST) begin
          cnt_nx = '0;
          if (layer != LAYER_LAST) begin
            state_nx = RD;
            layer_nx = layer + 1'b1;
          end else if (syndrome_ok || itr == ITR_LAST) begin
            state_nx = UNLOAD;
          end else begin
            state_nx = RD;
            layer_nx = 1'b0;
            itr_nx   = itr + ITRWIDTH'(1);
          end
        end else begin
          cnt_nx = cnt + CNTW'(1);
        end
      end
      UNLOAD: begin
        if (cnt == UNL_LAST) begin
          state_nx = FIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNTW'(1);
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign loaden                   = (state == LOAD) && load_valid;
  assign rd_en                    = (state == RD);
  assign rd_address               = rd_en ? cnt[ADDRESSWIDTH-1:0] : '0;
  assign rd_layer                 = rd_en && layer;
  assign wr_en                    = wd_en[WR_DELAY-1];
  assign wr_layer                 = wd_layer[WR_DELAY-1];
  assign firstprocessing_indicate = ((state == RD) || (state == DRAIN)) && (itr == '0);
  assign unload_en                = (state == UNLOAD) && (cnt < UNL_DEPTH_C);
  assign unloadAddress            = unload_en ? cnt[ADDRESSWIDTH-1:0] : '0;
  assign hd_valid                 = hd_pipe[UNLOAD_LAT-1];
  assign itr_count                = itr;
  assign busy                     = (state != IDLE);
  assign done                     = (state == FIN);

endmodule
